// File: rtl/mc_datapath_p.sv
// mc_datapath_p: multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with a single
// shared request/ack memory port.
// Optional feature: define MC_DATAPATH_P_RETIRE_CNT_EN to build the 32-bit retired-instruction
// counter; without it, 'retired' is tied to zero.
module mc_datapath_p #(
    parameter int DATA_W   = 32,
    parameter int REG_N    = 32,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [DATA_W-1:0] curr_pc,
    output logic [31:0]       retired
);
    localparam int IDX_W = $clog2(REG_N);
    localparam logic [DATA_W-1:0] PC_INC  = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] PC_BOOT = DATA_W'(RESET_PC);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;
    logic [DATA_W-1:0]  regs_q [REG_N];

    logic               rf_we;
    logic [IDX_W-1:0]   rf_idx;
    logic [DATA_W-1:0]  rf_data;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [IDX_W-1:0]   rs_idx;
    logic [IDX_W-1:0]   rt_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  imm_sext;
    logic [DATA_W-1:0]  br_off;
    logic [DATA_W-1:0]  jump_target;
    logic [DATA_W-1:0]  alu_res;
    logic               op_valid;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: IDX_W];
    assign rt_idx   = ir_q[16 +: IDX_W];
    assign rd_idx   = ir_q[11 +: IDX_W];
    assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign br_off   = imm_sext * PC_INC;

    // Jump target keeps the upper PC bits; byte addressing appends two zero bits.
    always_comb begin
        if (PC_STEP == 4) begin
            jump_target = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
        end else begin
            jump_target = {pc_q[DATA_W-1:26], ir_q[25:0]};
        end
    end

    // Flag any opcode/funct outside the supported subset so DECODE can divert to HALT.
    always_comb begin
        op_valid = 1'b0;
        case (opcode)
            OP_RTYPE: op_valid = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                                 (funct == F_OR)  || (funct == F_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    // ALU: R-type uses A op B, everything else is A plus the sign-extended immediate.
    always_comb begin
        alu_res = a_q + imm_sext;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    // Control FSM next state plus the datapath register updates for each step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        rf_idx  = '0;
        rf_data = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + PC_INC;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs_idx];
                b_d     = regs_q[rt_idx];
                alu_d   = pc_q + br_off;
                state_d = op_valid ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: begin
                        alu_d   = alu_res;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_sext;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = alu_q;
                        end
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jump_target;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (opcode == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_idx  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
                rf_data = (opcode == OP_LW) ? mdr_q : alu_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= PC_BOOT;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file; entry 0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && (rf_idx != '0)) begin
            regs_q[rf_idx] <= rf_data;
        end
    end

    // The request is gated by rst itself so a reset mid-access drops it without waiting a clock.
    assign mem_req   = rst && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = (state_q == S_MEM) && (opcode == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_wdata = b_q;
    assign halted    = (state_q == S_HALT);
    assign curr_pc   = pc_q;

`ifdef MC_DATAPATH_P_RETIRE_CNT_EN
    logic        retire;
    logic [31:0] retired_q, retired_d;

    // An instruction retires as it leaves WB, MEM for a store, or EXEC for beq/j.
    always_comb begin
        retire = (state_q == S_WB) ||
                 ((state_q == S_MEM) && mem_ack && (opcode == OP_SW)) ||
                 ((state_q == S_EXEC) && ((opcode == OP_BEQ) || (opcode == OP_J)));
        retired_d = retired_q + {31'd0, retire};
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_mc_datapath_p.sv
// Self-checking bench for mc_datapath_p: directed programs on a 32-bit word-addressed core
// (RESET_PC=64) with a delay-programmable memory responder, plus a 64-bit core with ack tied high.
module tb_mc_datapath_p;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr64_t;

`ifdef MC_DATAPATH_P_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, curr_pc, retired;

    logic        rst64;
    logic        mem_req64, mem_we64, halted64;
    logic [63:0] mem_addr64, mem_wdata64, mem_rdata64, curr_pc64;
    logic [31:0] retired64;

    logic [31:0] mem   [0:255];
    logic [31:0] rom64 [0:15];

    acc_t        acc_log[$];
    wr64_t       wr64_log[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          ack_delay = 0;
    bit          block_data = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;

    mc_datapath_p #(.DATA_W(32), .REG_N(32), .PC_STEP(1), .RESET_PC(64)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .curr_pc(curr_pc), .retired(retired)
    );

    mc_datapath_p #(.DATA_W(64), .REG_N(8), .PC_STEP(1), .RESET_PC(0)) dut64 (
        .clk(clk), .rst(rst64),
        .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
        .mem_rdata(mem_rdata64), .mem_ack(1'b1),
        .halted(halted64), .curr_pc(curr_pc64), .retired(retired64)
    );

    assign mem_rdata64 = {32'd0, rom64[mem_addr64[3:0]]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count the outcome.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expRet(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    // Memory responder: acks after ack_delay waiting cycles and checks the request stays put.
    always @(negedge clk) begin
        if (rst && mem_req) begin
            if (wait_cnt == 0) begin
                req_addr  = mem_addr;
                req_we    = mem_we;
                req_wdata = mem_wdata;
            end else begin
                checkOutput("stable_addr", mem_addr, req_addr);
                checkOutput("stable_we", mem_we, req_we);
                if (req_we) checkOutput("stable_wdata", mem_wdata, req_wdata);
            end
            if (wait_cnt >= ack_delay && !(block_data && mem_addr < 32)) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
                if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
                acc_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            if (rst && wait_cnt != 0) checkOutput("req_held", mem_req, 1'b1);
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Record the 64-bit core's stores; its ack is tied high so each lasts one cycle.
    always @(negedge clk) begin
        if (rst64 && mem_req64 && mem_we64) begin
            wr64_log.push_back('{addr: mem_addr64, data: mem_wdata64});
        end
    end

    // Assert reset and clear memory and logs; the caller loads the program afterwards.
    task automatic applyStimulus(input int delay, input bit block);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_delay  = delay;
        block_data = block;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        acc_log.delete();
        exp_wa.delete();
        exp_wd.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic waitAccess(input string tag, input logic [31:0] addr, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == addr) found = 1'b1;
        end
        checkOutput(tag, found, 1'b1);
    endtask

    task automatic waitHalt(input string tag, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        checkOutput(tag, found, 1'b1);
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic checkWrites(input string tag);
        acc_t wr[$];
        foreach (acc_log[i]) if (acc_log[i].we) wr.push_back(acc_log[i]);
        checkOutput({tag, "_nwr"}, wr.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < wr.size(); i++) begin
            checkOutput({tag, "_waddr"}, wr[i].addr, exp_wa[i]);
            checkOutput({tag, "_wdata"}, wr[i].data, exp_wd[i]);
        end
    endtask

    logic [31:0] halt_word;
    logic [5:0]  OPI, OPLW, OPSW, OPBEQ;

    initial begin
        halt_word = 32'hFC00_0000;
        OPI = 6'b001000; OPLW = 6'b100011; OPSW = 6'b101011; OPBEQ = 6'b000100;
        rst = 1'b0; rst64 = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;

        // 64-bit core program runs alongside the 32-bit tests and is checked at the end.
        for (int i = 0; i < 16; i++) rom64[i] = 32'd0;
        rom64[0] = encI(OPI, 5'd0, 5'd1, 16'hFFFF);
        rom64[1] = encR(5'd2, 5'd1, 5'd1, 6'b100000);
        rom64[2] = encI(OPI, 5'd0, 5'd0, 16'd9);
        rom64[3] = encI(OPSW, 5'd0, 5'd2, 16'd32);
        rom64[4] = encI(OPSW, 5'd0, 5'd0, 16'd33);
        rom64[5] = halt_word;

        // Test A: reset values, ALU ops, stores with ack tied high.
        applyStimulus(0, 1'b0);
        checkOutput("rst_req", mem_req, 1'b0);
        checkOutput("rst_halted", halted, 1'b0);
        checkOutput("rst_pc", curr_pc, 32'd64);
        checkOutput("rst_retired", retired, 32'd0);
        mem[64] = encI(OPI, 5'd0, 5'd1, 16'd5);
        mem[65] = encI(OPI, 5'd0, 5'd2, 16'd7);
        mem[66] = encR(5'd3, 5'd1, 5'd2, 6'b100000);
        mem[67] = encR(5'd5, 5'd1, 5'd2, 6'b100010);
        mem[68] = encR(5'd6, 5'd5, 5'd1, 6'b101010);
        mem[69] = encR(5'd7, 5'd1, 5'd2, 6'b100100);
        mem[70] = encR(5'd8, 5'd1, 5'd2, 6'b100101);
        mem[71] = encI(OPSW, 5'd0, 5'd3, 16'd4);
        mem[72] = encI(OPSW, 5'd0, 5'd5, 16'd5);
        mem[73] = encI(OPSW, 5'd0, 5'd6, 16'd6);
        mem[74] = encI(OPSW, 5'd0, 5'd7, 16'd7);
        mem[75] = encI(OPSW, 5'd0, 5'd8, 16'd8);
        mem[76] = halt_word;
        rst64 = 1'b1;
        releaseReset();
        waitAccess("a_fetch67", 32'd67, 100);
        checkOutput("a_pc3", curr_pc, 32'd67);
        checkOutput("a_ret3", retired, expRet(3));
        waitHalt("a_halt", 300);
        checkOutput("a_pc_end", curr_pc, 32'd77);
        checkOutput("a_ret_end", retired, expRet(12));
        expectWrite(32'd4, 32'd12);
        expectWrite(32'd5, 32'hFFFF_FFFE);
        expectWrite(32'd6, 32'd1);
        expectWrite(32'd7, 32'd5);
        expectWrite(32'd8, 32'd7);
        checkWrites("a");

        // Test B: store then load back with three wait cycles on every access.
        applyStimulus(3, 1'b0);
        mem[64] = encI(OPI, 5'd0, 5'd1, 16'd5);
        mem[65] = encI(OPI, 5'd0, 5'd2, 16'd7);
        mem[66] = encR(5'd3, 5'd1, 5'd2, 6'b100000);
        mem[67] = encI(OPSW, 5'd0, 5'd3, 16'd4);
        mem[68] = encI(OPLW, 5'd0, 5'd4, 16'd4);
        mem[69] = encI(OPSW, 5'd0, 5'd4, 16'd8);
        mem[70] = halt_word;
        releaseReset();
        waitHalt("b_halt", 500);
        checkOutput("b_ret", retired, expRet(6));
        expectWrite(32'd4, 32'd12);
        expectWrite(32'd8, 32'd12);
        checkWrites("b");

        // Test C: jump to 10, then a taken and a not-taken beq.
        for (int t = 0; t < 2; t++) begin
            applyStimulus(0, 1'b0);
            mem[64] = encI(OPI, 5'd0, 5'd1, 16'd5);
            mem[65] = encI(OPI, 5'd0, 5'd2, 16'd7);
            mem[66] = {6'b000010, 26'd10};
            mem[10] = encI(OPBEQ, 5'd1, (t == 0) ? 5'd1 : 5'd2, 16'd2);
            mem[13] = halt_word;
            mem[11] = halt_word;
            releaseReset();
            waitHalt("c_halt", 200);
            checkOutput("c_len", acc_log.size(), 5);
            if (acc_log.size() >= 5) begin
                checkOutput("c_jtarget", acc_log[3].addr, 32'd10);
                checkOutput("c_beq_next", acc_log[4].addr, (t == 0) ? 32'd13 : 32'd11);
            end
            checkOutput("c_ret", retired, expRet(4));
        end

        // Test D: illegal opcode halts for good.
        applyStimulus(0, 1'b0);
        mem[64] = encI(OPI, 5'd0, 5'd1, 16'd1);
        mem[65] = halt_word;
        releaseReset();
        waitHalt("d_halt", 100);
        checkOutput("d_ret", retired, expRet(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("d_req_low", mem_req, 1'b0);
        end
        checkOutput("d_halted", halted, 1'b1);
        checkOutput("d_ret_hold", retired, expRet(1));
        checkOutput("d_pc", curr_pc, 32'd66);

        // Test E: reset while a load is waiting for its ack.
        applyStimulus(0, 1'b1);
        mem[64] = encI(OPLW, 5'd0, 5'd4, 16'd4);
        releaseReset();
        waitAccess("e_lw_pending", 32'd4, 50);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("e_req_drop", mem_req, 1'b0);
        checkOutput("e_pc_rst", curr_pc, 32'd64);
        checkOutput("e_ret_rst", retired, 32'd0);
        @(posedge clk);
        acc_log.delete();
        block_data = 1'b0;
        releaseReset();
        @(negedge clk);
        #1;
        checkOutput("e_req_up", mem_req, 1'b1);
        checkOutput("e_fetch_addr", mem_addr, 32'd64);
        checkOutput("e_first_log", acc_log.size(), 1);
        if (acc_log.size() >= 1) checkOutput("e_first_addr", acc_log[0].addr, 32'd64);
        waitHalt("e_halt", 100);
        checkOutput("e_ret", retired, expRet(1));

        // 64-bit core results.
        checkOutput("w_halted", halted64, 1'b1);
        checkOutput("w_pc", curr_pc64, 64'd6);
        checkOutput("w_ret", {32'd0, retired64}, {32'd0, expRet(5)});
        checkOutput("w_nwr", wr64_log.size(), 2);
        if (wr64_log.size() >= 2) begin
            checkOutput("w_addr0", wr64_log[0].addr, 64'd32);
            checkOutput("w_data0", wr64_log[0].data, 64'hFFFF_FFFF_FFFF_FFFE);
            checkOutput("w_addr1", wr64_log[1].addr, 64'd33);
            checkOutput("w_r0", wr64_log[1].data, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mc_datapath_p.md
MC_DATAPATH_P -- requirements
Module: mc_datapath_p

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width; legal values 32 and 64 only.
REQ-002 Parameter REG_N, default 32, register-file entries; power of two, 8 to 32; register index = low log2(REG_N) bits of the 5-bit instruction field.
REQ-003 Parameter PC_STEP, default 1, PC increment per instruction (1 = word addressing, 4 = byte addressing).
REQ-004 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 mem_req  out  1  memory access request; held high until accepted.
REQ-008 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-009 mem_addr  out  DATA_W  access address; valid while mem_req is high.
REQ-010 mem_wdata  out  DATA_W  store data; valid while mem_req and mem_we are high.
REQ-011 mem_rdata  in  DATA_W  read data; sampled on the cycle mem_ack is high.
REQ-012 mem_ack  in  1  access completes on a cycle where mem_req and mem_ack are both high; ignored when mem_req is low.
REQ-013 halted  out  1  core stopped in HALT.
REQ-014 curr_pc  out  DATA_W  current PC register.
REQ-015 retired  out  32  retired-instruction count (see Configuration).

Function
REQ-016 Control FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT. Ordering per instruction is fixed by REQ-020 to REQ-025.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on ack, IR<=mem_rdata[31:0] and PC<=PC+PC_STEP.
REQ-018 DECODE: A<=reg[rs] and B<=reg[rt]; ALUOut<=PC+(sext(imm16)*PC_STEP).
REQ-019 Supported opcodes: R-type 000000 (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-020 R-type: EXEC then WB writes rd; 4 cycles plus fetch wait states.
REQ-021 addi: EXEC then WB writes rt; 4 cycles plus fetch wait states.
REQ-022 lw: EXEC computes A+sext(imm); MEM reads until ack; WB writes rt; 5 cycles plus wait states.
REQ-023 sw: EXEC, then MEM writes B until ack; 4 cycles plus wait states.
REQ-024 beq: EXEC sets PC<=ALUOut if A==B; 3 cycles.
REQ-025 j: EXEC sets PC<={PC[DATA_W-1:28], IR[25:0], 2'b00} when PC_STEP=4, or {PC[DATA_W-1:26], IR[25:0]} when PC_STEP=1; 3 cycles.
REQ-026 Any other opcode or funct enters HALT; HALT is terminal until reset, mem_req=0, halted=1.
REQ-027 Arithmetic wraps modulo 2^DATA_W; slt is signed; no overflow trap.
REQ-028 Register 0 always reads 0; writes to it are discarded.
REQ-029 mem_req deasserts the cycle after the accepting ack; mem_addr, mem_we and mem_wdata stay stable while the request is pending.
REQ-030 Instruction completion: retire pulses on leaving WB, leaving MEM for sw, or leaving EXEC for beq and j; the state then returns to FETCH.

Reset
REQ-031 While rst=0: PC=RESET_PC, state=FETCH, IR/A/B/ALUOut=0, all registers=0, mem_req=0, halted=0, retired=0.
REQ-032 Reset asserted mid-access drops mem_req immediately, with no ack handshake; a pending store is abandoned.
REQ-033 After rst rises, mem_req is high on the first rising clock edge.

Configuration
REQ-034 Macro MC_DATAPATH_P_RETIRE_CNT_EN: when defined, retired increments by 1 per retired instruction and wraps at 2^32; when undefined, retired is constant 0 and the counter is not synthesised.

Verification
REQ-035 Reset, then mem_ack tied high, program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, retired=3 with macro enabled, curr_pc=RESET_PC+3 at PC_STEP=1.
REQ-036 sw r3,4(r0) then lw r4,4(r0) with a 3-cycle ack delay on every access -> write access addr=4, wdata=12; r4=12; mem_req stable through each delay.
REQ-037 beq r1,r1,+2 at PC 10 (PC_STEP=1) -> next fetch addr 13; beq r1,r2 -> next fetch addr 11.
REQ-038 Opcode 111111 fetched -> halted=1, mem_req stays 0 for 20 cycles, retired unchanged.
REQ-039 rst pulled low during a pending lw (mem_req=1, no ack) -> mem_req=0 in the same cycle, curr_pc=RESET_PC; after release, fetch restarts at RESET_PC.
REQ-040 DATA_W=64, addi r1,r0,-1 then add r2,r1,r1 -> r2=0xFFFF_FFFF_FFFF_FFFE; addi r0,r0,9 -> r0 reads 0.
